ucsbece154b_bpred_v2: RTL and testbench
=======================================

Name: ucsbece154b_bpred_v2

Overview:
Next-generation fetch-stage branch predictor with a parametrised direct-mapped tagged BTB and a PHT of N-bit saturating counters. Direction mode is runtime-selectable: static not-taken, bimodal or gshare. Adds a return address stack, a speculative GHR with mispredict repair, and a GHR snapshot that travels down the pipeline. Fetch gets a same-cycle prediction from pc_i; execute sends one resolved control-flow update per cycle.

Parameters:
NUM_BTB_ENTRIES, 32, BTB entries, power of two ≥2
BTB_TAG_BITS, 10, partial tag width stored per entry
NUM_GHR_BITS, 6, history length; PHT has 2^NUM_GHR_BITS entries
CTR_BITS, 2, PHT counter width, ≥2
RAS_DEPTH, 8, return stack entries, power of two

Ports:
clk  in  1  clock; single clock domain
reset_ni  in  1  reset; one clock, reset is synchronous and active-low
mode_i  in  2  0=static NT, 1=bimodal, 2=gshare, 3=treated as gshare
fetch_valid_i  in  1  pc_i is a real fetch this cycle
pc_i  in  32  fetch PC
pred_taken_o  out  1  redirect fetch
pred_target_o  out  32  predicted target
btb_hit_o  out  1  valid entry with tag match
pred_type_o  out  2  BR=0, JMP=1, CALL=2, RET=3 (0 when miss)
ghr_o  out  NUM_GHR_BITS  GHR value used for this lookup; piped to execute
upd_valid_i  in  1  resolved control-flow instruction
upd_pc_i  in  32  its PC
upd_type_i  in  2  BR/JMP/CALL/RET
upd_taken_i  in  1  actual direction (1 for jumps)
upd_target_i  in  32  actual target
upd_mispredict_i  in  1  prediction was wrong (direction or target)
upd_ghr_i  in  NUM_GHR_BITS  ghr_o snapshot carried with the instruction

Behaviour:
- Reset (reset_ni=0 at posedge): all BTB valid=0; PHT = 2^(CTR_BITS-1)-1 (weakly NT); GHR=0; RAS pointer and count=0. Post-reset outputs: pred_taken_o=0, pred_target_o=0, btb_hit_o=0, pred_type_o=0, ghr_o=0. Reset overrides every other input.
- BTB index=pc[IDX+1:2], tag=pc[IDX+2+BTB_TAG_BITS-1:IDX+2], IDX=clog2(NUM_BTB_ENTRIES).
- PHT index: bimodal pc[H+1:2]; gshare pc[H+1:2]^GHR (H=NUM_GHR_BITS). Update side uses upd_pc_i and upd_ghr_i under the current mode_i.
- Prediction is combinational, zero latency. Miss: taken=0, target=0. BR: taken=counter MSB (0 in mode 0), target=BTB. JMP/CALL: taken=1, target=BTB. RET: taken=1, target=RAS top; if RAS empty, target=BTB.
- Spec GHR: at posedge with fetch_valid_i & hit & type BR, GHR<={GHR[H-2:0],pred_taken_o}.
- RAS push (pc_i+4) on fetch_valid_i & hit CALL; pop on hit RET. Push when full overwrites the oldest entry, wrapping; count saturates at RAS_DEPTH. Pop when empty is a no-op. The RAS is not repaired on mispredict.
- Update at posedge when upd_valid_i:
  - BR: PHT counter saturating ±1 per upd_taken_i; no wrap at 0 or max.
  - BTB write (valid, tag, type, target) when upd_taken_i=1. Not-taken branches never allocate or modify. Replacement is direct-mapped overwrite.
  - upd_mispredict_i: GHR<={upd_ghr_i[H-2:0],upd_taken_i} for BR, GHR<=upd_ghr_i otherwise. This overrides a same-cycle speculative shift.
- Same-cycle update and lookup of the same entry: the lookup sees old contents; there is no bypass.
- Mode change takes effect next lookup; tables are not cleared.

Decomposition:
- Package ucsbece154b_bpred_pkg: type encodings BR/JMP/CALL/RET, mode encodings, PHT reset-value function.
- Sub-module ucsbece154b_ras: circular stack with push/pop/empty/top and wrap-on-full.
- BTB, PHT and GHR stay in the top level.

Test Plan:
- Reset then pc_i=0x100, no updates -> btb_hit_o=0, pred_taken_o=0, ghr_o=0; reset_ni low mid-run clears a filled BTB: next lookup misses.
- Update BR pc=0x200 taken target=0x80 twice in mode 1 -> lookup 0x200: hit, type 0, taken=1 (counter 01→10→11); four NT updates -> counter 00, taken=0, no underflow wrap.
- Gshare aliasing: same PC, GHR 0 vs 0x3F -> distinct PHT indices; mispredict with upd_ghr_i=0x15, taken=1 -> GHR=0x2B (H=6) even with a concurrent fetch-side shift.
- CALL at 0x300 (target 0x1000), RET at 0x1010 both in BTB -> fetching 0x300 then 0x1010 predicts 0x304; with RAS empty, RET falls back to BTB target.
- Nine CALL fetches with RAS_DEPTH=8 then nine RETs -> the first eight pops return the newest eight addresses in LIFO order; the ninth uses the BTB fallback.
- Same-cycle update and lookup of idx 5 -> the old entry is returned; the next cycle returns the new entry.

Source files
------------

// File: rtl/ucsbece154b_bpred_pkg.sv
// Shared encodings and helpers for the ucsbece154b branch predictor.
package ucsbece154b_bpred_pkg;

    // Control-flow instruction class stored in the BTB
    typedef enum logic [1:0] {
        CF_BR   = 2'd0,
        CF_JMP  = 2'd1,
        CF_CALL = 2'd2,
        CF_RET  = 2'd3
    } cf_type_e;

    // Direction-prediction mode; the fourth code behaves as gshare
    typedef enum logic [1:0] {
        MODE_STATIC     = 2'd0,
        MODE_BIMODAL    = 2'd1,
        MODE_GSHARE     = 2'd2,
        MODE_GSHARE_ALT = 2'd3
    } mode_e;

    // Weakly-not-taken counter value: 2^(ctr_bits-1)-1
    function automatic int unsigned pht_reset_value(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/ucsbece154b_ras.sv
// Circular return address stack. A push when full overwrites the oldest
// entry; a pop when empty is ignored.
module ucsbece154b_ras
    import ucsbece154b_bpred_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_ni,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);

    logic [31:0]   mem_r [DEPTH];
    logic [PW-1:0] ptr_r;      // next free slot; top sits one below
    logic [PW:0]   count_r;

    assign top   = mem_r[ptr_r - PW'(1)];
    assign empty = (count_r == {(PW + 1){1'b0}});

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            ptr_r   <= {PW{1'b0}};
            count_r <= {(PW + 1){1'b0}};
        end else if (push) begin
            ptr_r <= ptr_r + PW'(1);
            if (count_r != CNT_FULL) begin
                count_r <= count_r + (PW + 1)'(1);
            end
        end else if (pop && !empty) begin
            ptr_r   <= ptr_r - PW'(1);
            count_r <= count_r - (PW + 1)'(1);
        end
    end

    // Storage write; wrapping pointer makes a full push replace the oldest
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/ucsbece154b_bpred_v2.sv
// Fetch-stage branch predictor: tagged direct-mapped BTB, PHT of saturating
// counters (static / bimodal / gshare), speculative GHR with repair, and RAS.
module ucsbece154b_bpred_v2
    import ucsbece154b_bpred_pkg::*;
#(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int BTB_TAG_BITS    = 10,
    parameter int NUM_GHR_BITS    = 6,
    parameter int CTR_BITS        = 2,
    parameter int RAS_DEPTH       = 8
) (
    input  logic                    clk,
    input  logic                    reset_ni,
    input  logic [1:0]              mode_i,
    input  logic                    fetch_valid_i,
    input  logic [31:0]             pc_i,
    output logic                    pred_taken_o,
    output logic [31:0]             pred_target_o,
    output logic                    btb_hit_o,
    output logic [1:0]              pred_type_o,
    output logic [NUM_GHR_BITS-1:0] ghr_o,
    input  logic                    upd_valid_i,
    input  logic [31:0]             upd_pc_i,
    input  logic [1:0]              upd_type_i,
    input  logic                    upd_taken_i,
    input  logic [31:0]             upd_target_i,
    input  logic                    upd_mispredict_i,
    input  logic [NUM_GHR_BITS-1:0] upd_ghr_i
);

    localparam int IDX   = $clog2(NUM_BTB_ENTRIES);
    localparam int H     = NUM_GHR_BITS;
    localparam int PHT_N = 1 << H;
    localparam logic [CTR_BITS-1:0] PHT_INIT = CTR_BITS'(pht_reset_value(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_MIN  = {CTR_BITS{1'b0}};

    // PHT index: PC bits alone for static/bimodal, XOR with history otherwise
    function automatic logic [H-1:0] pht_index(input logic [1:0] mode,
                                               input logic [31:0] pc,
                                               input logic [H-1:0] hist);
        logic [H-1:0] base;
        base = pc[H+1:2];
        case (mode)
            MODE_STATIC, MODE_BIMODAL: return base;
            default:                   return base ^ hist;
        endcase
    endfunction

    logic                    btb_valid_r  [NUM_BTB_ENTRIES];
    logic [BTB_TAG_BITS-1:0] btb_tag_r    [NUM_BTB_ENTRIES];
    cf_type_e                btb_type_r   [NUM_BTB_ENTRIES];
    logic [31:0]             btb_target_r [NUM_BTB_ENTRIES];
    logic [CTR_BITS-1:0]     pht_r        [PHT_N];
    logic [H-1:0]            ghr_r;

    logic [IDX-1:0]          lk_idx_s;
    logic [BTB_TAG_BITS-1:0] lk_tag_s;
    logic                    lk_hit_s;
    cf_type_e                lk_type_s;
    logic [CTR_BITS-1:0]     lk_ctr_s;
    logic [IDX-1:0]          upd_idx_s;
    logic [H-1:0]            upd_pht_idx_s;
    logic [CTR_BITS-1:0]     upd_ctr_s;
    logic [CTR_BITS-1:0]     upd_ctr_next_s;
    logic                    btb_we_s;
    logic                    pht_we_s;
    logic [H-1:0]            ghr_next_s;
    logic                    ras_push_s;
    logic                    ras_pop_s;
    logic [31:0]             ras_top_s;
    logic                    ras_empty_s;
    logic                    unused_bits_s;

    assign lk_idx_s  = pc_i[IDX+1:2];
    assign lk_tag_s  = pc_i[IDX+2+BTB_TAG_BITS-1:IDX+2];
    assign upd_idx_s = upd_pc_i[IDX+1:2];
    assign ghr_o     = ghr_r;
    assign unused_bits_s = ^{pc_i, upd_pc_i};

    // Same-cycle lookup: BTB tag compare, PHT read, output selection
    always_comb begin
        lk_hit_s      = btb_valid_r[lk_idx_s] && (btb_tag_r[lk_idx_s] == lk_tag_s);
        lk_type_s     = btb_type_r[lk_idx_s];
        lk_ctr_s      = pht_r[pht_index(mode_i, pc_i, ghr_r)];
        pred_taken_o  = 1'b0;
        pred_target_o = 32'd0;
        btb_hit_o     = lk_hit_s;
        pred_type_o   = CF_BR;
        if (lk_hit_s) begin
            pred_type_o = lk_type_s;
            case (lk_type_s)
                CF_BR: begin
                    pred_taken_o  = (mode_i == MODE_STATIC) ? 1'b0 : lk_ctr_s[CTR_BITS-1];
                    pred_target_o = btb_target_r[lk_idx_s];
                end
                CF_RET: begin
                    pred_taken_o  = 1'b1;
                    pred_target_o = ras_empty_s ? btb_target_r[lk_idx_s] : ras_top_s;
                end
                default: begin
                    pred_taken_o  = 1'b1;
                    pred_target_o = btb_target_r[lk_idx_s];
                end
            endcase
        end else begin
            pred_taken_o = 1'b0;
        end
    end

    // RAS control from hit CALL/RET fetches
    always_comb begin
        ras_push_s = fetch_valid_i && lk_hit_s && (lk_type_s == CF_CALL);
        ras_pop_s  = fetch_valid_i && lk_hit_s && (lk_type_s == CF_RET);
    end

    // Resolved-update datapath: saturating counter step and write enables
    always_comb begin
        upd_pht_idx_s = pht_index(mode_i, upd_pc_i, upd_ghr_i);
        upd_ctr_s     = pht_r[upd_pht_idx_s];
        pht_we_s      = upd_valid_i && (upd_type_i == CF_BR);
        btb_we_s      = upd_valid_i && upd_taken_i;
        if (upd_taken_i) begin
            upd_ctr_next_s = (upd_ctr_s == CTR_MAX) ? upd_ctr_s : upd_ctr_s + CTR_BITS'(1);
        end else begin
            upd_ctr_next_s = (upd_ctr_s == CTR_MIN) ? upd_ctr_s : upd_ctr_s - CTR_BITS'(1);
        end
    end

    // GHR next value: mispredict repair wins over the speculative shift
    always_comb begin
        ghr_next_s = ghr_r;
        if (upd_valid_i && upd_mispredict_i) begin
            if (upd_type_i == CF_BR) begin
                ghr_next_s = {upd_ghr_i[H-2:0], upd_taken_i};
            end else begin
                ghr_next_s = upd_ghr_i;
            end
        end else if (fetch_valid_i && lk_hit_s && (lk_type_s == CF_BR)) begin
            ghr_next_s = {ghr_r[H-2:0], pred_taken_o};
        end else begin
            ghr_next_s = ghr_r;
        end
    end

    // Reset-bearing state: BTB valid bits, PHT counters, GHR
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
                btb_valid_r[i] <= 1'b0;
            end
            for (int i = 0; i < PHT_N; i++) begin
                pht_r[i] <= PHT_INIT;
            end
            ghr_r <= {H{1'b0}};
        end else begin
            if (btb_we_s) begin
                btb_valid_r[upd_idx_s] <= 1'b1;
            end
            if (pht_we_s) begin
                pht_r[upd_pht_idx_s] <= upd_ctr_next_s;
            end
            ghr_r <= ghr_next_s;
        end
    end

    // BTB payload; qualified by the valid bit so needs no reset
    always_ff @(posedge clk) begin
        if (btb_we_s) begin
            btb_tag_r[upd_idx_s]    <= upd_pc_i[IDX+2+BTB_TAG_BITS-1:IDX+2];
            btb_type_r[upd_idx_s]   <= cf_type_e'(upd_type_i);
            btb_target_r[upd_idx_s] <= upd_target_i;
        end
    end

    ucsbece154b_ras #(
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_ni  (reset_ni),
        .push      (ras_push_s),
        .pop       (ras_pop_s),
        .push_data (pc_i + 32'd4),
        .top       (ras_top_s),
        .empty     (ras_empty_s)
    );

endmodule

// File: tb/tb_ucsbece154b_bpred_v2.sv
// Directed self-checking bench for ucsbece154b_bpred_v2 (default parameters).
module tb_ucsbece154b_bpred_v2;
    import ucsbece154b_bpred_pkg::*;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic [1:0]  mode_i;
    logic        fetch_valid_i;
    logic [31:0] pc_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        btb_hit_o;
    logic [1:0]  pred_type_o;
    logic [5:0]  ghr_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic [1:0]  upd_type_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_mispredict_i;
    logic [5:0]  upd_ghr_i;

    int total = 0;
    int bad   = 0;

    ucsbece154b_bpred_v2 dut (
        .clk              (clk),
        .reset_ni         (reset_ni),
        .mode_i           (mode_i),
        .fetch_valid_i    (fetch_valid_i),
        .pc_i             (pc_i),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .btb_hit_o        (btb_hit_o),
        .pred_type_o      (pred_type_o),
        .ghr_o            (ghr_o),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_type_i       (upd_type_i),
        .upd_taken_i      (upd_taken_i),
        .upd_target_i     (upd_target_i),
        .upd_mispredict_i (upd_mispredict_i),
        .upd_ghr_i        (upd_ghr_i)
    );

    // Free-running clock, 10 ns period
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [1:0] t, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic mp, input logic [5:0] g);
        upd_valid_i      = 1'b1;
        upd_type_i       = t;
        upd_pc_i         = pc;
        upd_taken_i      = tk;
        upd_target_i     = tgt;
        upd_mispredict_i = mp;
        upd_ghr_i        = g;
        tick();
        upd_valid_i      = 1'b0;
        upd_mispredict_i = 1'b0;
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_ni = 1'b0; mode_i = 2'd1; fetch_valid_i = 1'b0; pc_i = 32'd0;
        upd_valid_i = 1'b0; upd_pc_i = 32'd0; upd_type_i = 2'd0; upd_taken_i = 1'b0;
        upd_target_i = 32'd0; upd_mispredict_i = 1'b0; upd_ghr_i = 6'd0;
        tick(); tick();
        reset_ni = 1'b1;

        // Post-reset lookup misses
        pc_i = 32'h100; fetch_valid_i = 1'b1; #1;
        chk("rst_hit",    32'(btb_hit_o),    32'd0);
        chk("rst_taken",  32'(pred_taken_o), 32'd0);
        chk("rst_target", pred_target_o,     32'd0);
        chk("rst_type",   32'(pred_type_o),  32'd0);
        chk("rst_ghr",    32'(ghr_o),        32'd0);
        fetch_valid_i = 1'b0;

        // Bimodal training: counter 01 -> 10 -> 11
        mode_i = 2'd1;
        upd(CF_BR, 32'h200, 1'b1, 32'h80, 1'b0, 6'd0);
        upd(CF_BR, 32'h200, 1'b1, 32'h80, 1'b0, 6'd0);
        pc_i = 32'h200; #1;
        chk("br_hit",    32'(btb_hit_o),    32'd1);
        chk("br_type",   32'(pred_type_o),  32'd0);
        chk("br_taken",  32'(pred_taken_o), 32'd1);
        chk("br_target", pred_target_o,     32'h80);

        // Four not-taken: 11 -> 00, saturating (no wrap to 11)
        for (int i = 0; i < 4; i++) upd(CF_BR, 32'h200, 1'b0, 32'h0, 1'b0, 6'd0);
        #1;
        chk("nt_sat_taken", 32'(pred_taken_o), 32'd0);
        chk("nt_keep_hit",  32'(btb_hit_o),    32'd1);
        chk("nt_keep_tgt",  pred_target_o,     32'h80);
        upd(CF_BR, 32'h200, 1'b1, 32'h80, 1'b0, 6'd0);   // 00 -> 01
        chk("ctr01_taken", 32'(pred_taken_o), 32'd0);
        upd(CF_BR, 32'h200, 1'b1, 32'h80, 1'b0, 6'd0);   // 01 -> 10
        chk("ctr10_taken", 32'(pred_taken_o), 32'd1);

        // Static mode never predicts a branch taken
        mode_i = 2'd0; #1;
        chk("static_taken",  32'(pred_taken_o), 32'd0);
        chk("static_target", pred_target_o,     32'h80);

        // Gshare: GHR 0 indexes the trained counter, GHR 3F an untrained one
        mode_i = 2'd2; #1;
        chk("gs_ghr0_taken", 32'(pred_taken_o), 32'd1);
        upd(CF_JMP, 32'h4, 1'b0, 32'h0, 1'b1, 6'h3F);
        chk("repair_jmp_ghr", 32'(ghr_o), 32'h3F);
        chk("gs_ghr3f_taken", 32'(pred_taken_o), 32'd0);
        mode_i = 2'd3; #1;
        chk("mode3_taken", 32'(pred_taken_o), 32'd0);
        mode_i = 2'd1; #1;
        chk("bimodal_ghr3f_taken", 32'(pred_taken_o), 32'd1);
        mode_i = 2'd2; #1;

        // Speculative shift of a predicted-not-taken branch: 3F -> 3E
        fetch_valid_i = 1'b1;
        tick();
        fetch_valid_i = 1'b0;
        chk("spec_ghr", 32'(ghr_o), 32'h3E);

        // Mispredict repair wins over a concurrent speculative shift
        fetch_valid_i = 1'b1; pc_i = 32'h200;
        upd(CF_BR, 32'h208, 1'b1, 32'h600, 1'b1, 6'h15);
        fetch_valid_i = 1'b0;
        chk("repair_br_ghr", 32'(ghr_o), 32'h2B);

        // CALL / RET through the RAS
        upd(CF_CALL, 32'h300, 1'b1, 32'h1000, 1'b0, 6'd0);
        upd(CF_RET, 32'h1010, 1'b1, 32'h2000, 1'b0, 6'd0);
        pc_i = 32'h1010; #1;
        chk("ret_hit",      32'(btb_hit_o),    32'd1);
        chk("ret_type",     32'(pred_type_o),  32'd3);
        chk("ret_taken",    32'(pred_taken_o), 32'd1);
        chk("ret_fallback", pred_target_o,     32'h2000);
        pc_i = 32'h300; #1;
        chk("call_type",   32'(pred_type_o),  32'd2);
        chk("call_taken",  32'(pred_taken_o), 32'd1);
        chk("call_target", pred_target_o,     32'h1000);
        fetch_valid_i = 1'b1;
        tick();
        pc_i = 32'h1010; #1;
        chk("ret_ras", pred_target_o, 32'h304);
        tick();
        fetch_valid_i = 1'b0; #1;
        chk("ret_after_pop", pred_target_o, 32'h2000);
        chk("ghr_unchanged", 32'(ghr_o), 32'h2B);

        // Nine CALLs into an eight-deep RAS, then nine RETs
        for (int k = 0; k < 9; k++) upd(CF_CALL, 32'h3000 + 32'(4 * (k + 8)), 1'b1, 32'h5000, 1'b0, 6'd0);
        fetch_valid_i = 1'b1;
        for (int k = 0; k < 9; k++) begin
            pc_i = 32'h3000 + 32'(4 * (k + 8));
            tick();
        end
        pc_i = 32'h1010;
        for (int j = 0; j < 9; j++) begin
            #1;
            chk($sformatf("ras_pop%0d", j), pred_target_o,
                (j < 8) ? 32'h3000 + 32'(4 * (16 - j)) + 32'd4 : 32'h2000);
            tick();
        end
        fetch_valid_i = 1'b0;

        // Same-cycle update and lookup of index 5: old entry first, new next
        upd(CF_JMP, 32'h14, 1'b1, 32'h700, 1'b0, 6'd0);
        pc_i = 32'h14; #1;
        chk("jmp_type",   32'(pred_type_o), 32'd1);
        chk("jmp_target", pred_target_o,    32'h700);
        upd_valid_i = 1'b1; upd_type_i = CF_JMP; upd_pc_i = 32'h14; upd_taken_i = 1'b1;
        upd_target_i = 32'h900; upd_mispredict_i = 1'b0; #1;
        chk("same_cycle_old", pred_target_o, 32'h700);
        tick();
        upd_valid_i = 1'b0; #1;
        chk("next_cycle_new", pred_target_o, 32'h900);

        // Mid-run reset clears the filled BTB and the GHR
        reset_ni = 1'b0;
        tick();
        reset_ni = 1'b1; #1;
        chk("rst2_hit",    32'(btb_hit_o),   32'd0);
        chk("rst2_target", pred_target_o,    32'd0);
        chk("rst2_ghr",    32'(ghr_o),       32'd0);
        pc_i = 32'h1010; #1;
        chk("rst2_ret_miss", 32'(btb_hit_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
